// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stalls, branch flushes and optional MDU stall tracking.
// Define HAZARD_MDU_EN to build the IDLE/BUSY multi-cycle mul/div tracker; otherwise it is absent.
//   state | meaning
//   IDLE  | no multi-cycle MDU op outstanding
//   BUSY  | MDU op in EX, pipeline held until mdu_done
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd_addr,
    input  logic                      id_ex_mem_read,
    input  logic                      id_ex_is_mdu,
    input  logic                      mdu_done,
    input  logic                      ex_branch_taken,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      stall_ex,
    output logic                      flush_if_id,
    output logic                      flush_id_ex,
    output logic                      mdu_busy,
    output logic                      mdu_timeout,
    output logic [31:0]               stall_count
);

    logic load_use;
    logic mdu_stall;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = id_ex_mem_read && (id_ex_rd_addr != '0) &&
                      ((id_uses_rs1 && (id_ex_rd_addr == id_rs1_addr)) ||
                       (id_uses_rs2 && (id_ex_rd_addr == id_rs2_addr)));

`ifdef HAZARD_MDU_EN
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic       stall_raw;
    logic [6:0] busy_cnt;
    logic       timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == BUSY) begin
                busy_cnt <= '0;
            end else if (state == BUSY && !mdu_done && busy_cnt != 7'd64) begin
                busy_cnt <= busy_cnt + 7'd1;
            end
            // Flag is sticky; the FSM keeps waiting for mdu_done regardless.
            if (state == BUSY && !mdu_done && busy_cnt == 7'd63) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        case (state)
            IDLE: begin
                if (id_ex_is_mdu && !mdu_done) begin
                    state_nxt = BUSY;
                    stall_raw = 1'b1;
                end
            end
            BUSY: begin
                if (mdu_done) begin
                    state_nxt = IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The IDLE-entry term is combinational, so mask it while reset is held.
    assign mdu_stall   = stall_raw && rst_n;
    assign mdu_busy    = (state == BUSY) && !mdu_done;
    assign mdu_timeout = timeout_q;
`else
    logic unused_mdu;

    assign unused_mdu  = id_ex_is_mdu ^ mdu_done;
    assign mdu_stall   = 1'b0;
    assign mdu_busy    = 1'b0;
    assign mdu_timeout = 1'b0;
`endif

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (mdu_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_if && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; MDU checks follow HAZARD_MDU_EN.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_ex_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_is_mdu, mdu_done, ex_branch_taken;
    logic        stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, mdu_busy, mdu_timeout;
    logic [31:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rd_addr(id_ex_rd_addr), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_is_mdu(id_ex_is_mdu), .mdu_done(mdu_done),
        .ex_branch_taken(ex_branch_taken),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout), .stall_count(stall_count)
    );

    // Packed outputs: {stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, mdu_busy, mdu_timeout}
    function automatic logic [6:0] outs();
        return {stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, mdu_busy, mdu_timeout};
    endfunction

    task automatic clear_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0; id_ex_rd_addr = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_ex_mem_read = 0;
        id_ex_is_mdu = 0; mdu_done = 0; ex_branch_taken = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        #1;
        n_vec++;
        if (outs() !== 7'b0000000 || stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_idle: outs=%b cnt=%0d expected outs=0000000 cnt=0", outs(), stall_count);
        end
        // Load-use term stays live in reset, but the counter must not move.
        id_ex_mem_read = 1; id_ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_uses_rs1 = 1;
        #1;
        n_vec++;
        if (outs() !== 7'b1100100) begin
            n_err++;
            $display("FAIL reset_load_use: outs=%b expected 1100100", outs());
        end
        @(negedge clk);
        n_vec++;
        if (stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_count_hold: cnt=%0d expected 0", stall_count);
        end
        clear_inputs();
        rst_n = 1;
    endtask

    task automatic test_load_use();
        logic [6:0] exp_tab [4];
        do_reset();
        // rs1 hit, rs2 hit, rs1 match but unused, different register
        exp_tab[0] = 7'b1100100; exp_tab[1] = 7'b1100100;
        exp_tab[2] = 7'b0000000; exp_tab[3] = 7'b0000000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            id_ex_mem_read = 1;
            id_ex_rd_addr  = 5'd5;
            case (i)
                0: begin id_rs1_addr = 5'd5; id_uses_rs1 = 1; end
                1: begin id_rs2_addr = 5'd5; id_uses_rs2 = 1; end
                2: begin id_rs1_addr = 5'd5; id_uses_rs1 = 0; end
                default: begin id_rs1_addr = 5'd6; id_uses_rs1 = 1; id_rs2_addr = 5'd4; id_uses_rs2 = 1; end
            endcase
            #1;
            n_vec++;
            if (outs() !== exp_tab[i]) begin
                n_err++;
                $display("FAIL load_use_%0d: outs=%b expected %b", i, outs(), exp_tab[i]);
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (stall_count !== 32'd2 || outs() !== 7'b0000000) begin
            n_err++;
            $display("FAIL load_use_count: cnt=%0d outs=%b expected cnt=2 outs=0000000", stall_count, outs());
        end
    endtask

    task automatic test_x0();
        do_reset();
        @(negedge clk);
        id_ex_mem_read = 1; id_ex_rd_addr = 5'd0;
        id_rs1_addr = 5'd0; id_uses_rs1 = 1; id_rs2_addr = 5'd0; id_uses_rs2 = 1;
        #1;
        n_vec++;
        if (outs() !== 7'b0000000) begin
            n_err++;
            $display("FAIL x0_no_hazard: outs=%b expected 0000000", outs());
        end
        @(negedge clk);
        clear_inputs();
        n_vec++;
        if (stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL x0_count: cnt=%0d expected 0", stall_count);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        @(negedge clk);
        id_ex_mem_read = 1; id_ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1;
        ex_branch_taken = 1;
        #1;
        n_vec++;
        if (outs() !== 7'b0001100) begin
            n_err++;
            $display("FAIL branch_over_load_use: outs=%b expected 0001100", outs());
        end
        @(negedge clk);
        id_ex_is_mdu = 1;
        #1;
        n_vec++;
`ifdef HAZARD_MDU_EN
        if (outs() !== 7'b1110000) begin
            n_err++;
            $display("FAIL mdu_over_branch: outs=%b expected 1110000", outs());
        end
`else
        if (outs() !== 7'b0001100) begin
            n_err++;
            $display("FAIL mdu_ignored_branch: outs=%b expected 0001100", outs());
        end
`endif
        @(negedge clk);
        clear_inputs();
        mdu_done = 1;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_mdu();
        logic [6:0] exp;
        do_reset();
        @(negedge clk);
        id_ex_is_mdu = 1;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            #1;
`ifdef HAZARD_MDU_EN
            exp = (c == 1) ? 7'b1110000 : 7'b1110010;
`else
            exp = 7'b0000000;
`endif
            n_vec++;
            if (outs() !== exp) begin
                n_err++;
                $display("FAIL mdu_cycle_%0d: outs=%b expected %b", c, outs(), exp);
            end
        end
        @(negedge clk);
        mdu_done = 1;
        #1;
        n_vec++;
        if (outs() !== 7'b0000000) begin
            n_err++;
            $display("FAIL mdu_done_cycle: outs=%b expected 0000000", outs());
        end
        @(negedge clk);
        clear_inputs();
        #1;
`ifdef HAZARD_MDU_EN
        exp = 7'd0;
        n_vec++;
        if (outs() !== exp || stall_count !== 32'd8) begin
            n_err++;
            $display("FAIL mdu_after: outs=%b cnt=%0d expected outs=0000000 cnt=8", outs(), stall_count);
        end
`else
        n_vec++;
        if (outs() !== 7'b0000000 || stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL mdu_after: outs=%b cnt=%0d expected outs=0000000 cnt=0", outs(), stall_count);
        end
`endif
        // Same-cycle done is a one-cycle op: no stall, no BUSY.
        @(negedge clk);
        id_ex_is_mdu = 1; mdu_done = 1;
        #1;
        n_vec++;
        if (outs() !== 7'b0000000) begin
            n_err++;
            $display("FAIL mdu_one_cycle: outs=%b expected 0000000", outs());
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (mdu_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mdu_one_cycle_idle: busy=%b expected 0", mdu_busy);
        end
    endtask

    task automatic test_timeout();
        logic exp_to;
        do_reset();
        @(negedge clk);
        id_ex_is_mdu = 1;
        @(negedge clk);
        repeat (63) @(negedge clk);
        #1;
        n_vec++;
        if (mdu_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: got %b expected 0", mdu_timeout);
        end
        @(negedge clk);
        #1;
`ifdef HAZARD_MDU_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        n_vec++;
        if (mdu_timeout !== exp_to || mdu_busy !== exp_to || stall_ex !== exp_to) begin
            n_err++;
            $display("FAIL timeout_set: to=%b busy=%b stall_ex=%b expected %b %b %b",
                     mdu_timeout, mdu_busy, stall_ex, exp_to, exp_to, exp_to);
        end
        @(negedge clk);
        mdu_done = 1;
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (mdu_timeout !== exp_to || mdu_busy !== 1'b0 || stall_if !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_sticky: to=%b busy=%b stall_if=%b expected %b 0 0",
                     mdu_timeout, mdu_busy, stall_if, exp_to);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        @(negedge clk);
        id_ex_is_mdu = 1;
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        n_vec++;
        if (outs() !== 7'b0000000 || stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_held: outs=%b cnt=%0d expected 0000000 0", outs(), stall_count);
        end
        @(negedge clk);
        id_ex_is_mdu = 0;
        rst_n = 1;
        #1;
        n_vec++;
        if (outs() !== 7'b0000000 || stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_release: outs=%b cnt=%0d expected 0000000 0", outs(), stall_count);
        end
        @(negedge clk);
        mdu_done = 1;
        #1;
        n_vec++;
        if (outs() !== 7'b0000000) begin
            n_err++;
            $display("FAIL late_done: outs=%b expected 0000000", outs());
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (outs() !== 7'b0000000 || stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL late_done_after: outs=%b cnt=%0d expected 0000000 0", outs(), stall_count);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_load_use();
        test_x0();
        test_branch_priority();
        test_mdu();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
